// File: rtl/fifo_collect.sv
// fifo_collect: serial-to-parallel deskew collector; drops SKEW leading samples,
// gathers the next DEPTH samples into q and holds them until read.
module fifo_collect #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8,
  parameter int SKEW  = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   en,
  input  logic signed [BITS-1:0] din,
  input  logic                   rd,
  output logic signed [BITS-1:0] q [DEPTH],
  output logic                   valid,
  output logic                   busy
);
  localparam int MX = (SKEW > DEPTH) ? SKEW : DEPTH;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] SKIP_LAST = CW'((SKEW > 0) ? SKEW - 1 : 0);
  localparam logic [CW-1:0] FILL_LAST = CW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, SKIP, FILL, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] skip_cnt, fill_cnt;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (start) nxt = (SKEW > 0) ? SKIP : FILL;
    else if (state == SKIP && en && skip_cnt == SKIP_LAST) nxt = FILL;
    else if (state == FILL && en && fill_cnt == FILL_LAST) nxt = DONE;
    else if (state == DONE && rd) nxt = IDLE;
  end
  always_comb begin
    valid = state == DONE;
    busy  = state == SKIP || state == FILL;
  end
  // shift toward q[0] so the first kept sample lands there after DEPTH shifts
  always_ff @(posedge clk)
    if (!rst_n || start) begin
      q        <= '{default: '0};
      skip_cnt <= '0;
      fill_cnt <= '0;
    end else if (en && state == SKIP) begin
      skip_cnt <= skip_cnt + 1'b1;
    end else if (en && state == FILL) begin
      for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      q[DEPTH-1] <= din;
      fill_cnt   <= fill_cnt + 1'b1;
    end
endmodule

// File: tb/tb_fifo_collect.sv
// tb_fifo_collect: directed checks of fifo_collect (8/8/7 and 4/8/0 configurations).
module tb_fifo_collect;
  logic clk = 0;
  logic rst_n, start, en, rd, start2, en2, rd2;
  logic signed [7:0] din, din2;
  logic signed [7:0] q [8];
  logic signed [7:0] q2 [4];
  logic valid, busy, valid2, busy2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fifo_collect dut (.clk(clk), .rst_n(rst_n), .start(start), .en(en), .din(din),
                    .rd(rd), .q(q), .valid(valid), .busy(busy));
  fifo_collect #(.DEPTH(4), .BITS(8), .SKEW(0)) dut2 (.clk(clk), .rst_n(rst_n),
    .start(start2), .en(en2), .din(din2), .rd(rd2), .q(q2), .valid(valid2), .busy(busy2));
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int s);
    en = 1;
    din = 8'(s);
    step();
    en = 0;
  endtask
  task automatic do_start();
    start = 1;
    step();
    start = 0;
  endtask
  task automatic check_q(input string tag, input int e [8]);
    for (int i = 0; i < 8; i++) chk($sformatf("%s q[%0d]", tag, i), int'(q[i]), e[i]);
  endtask
  int seq18 [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int zeros [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int ext [8]   = '{-128, 127, -1, 0, 1, -2, 64, -64};
  int seq21 [8] = '{21, 22, 23, 24, 25, 26, 27, 28};
  int early;
  initial begin
    rst_n = 0; start = 0; en = 0; din = 0; rd = 0;
    start2 = 0; en2 = 0; din2 = 0; rd2 = 0;
    step();
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    check_q("rst", zeros);
    rst_n = 1;
    // basic capture
    do_start();
    chk("start busy", busy, 1);
    for (int i = 0; i < 7; i++) send(8'h55);
    chk("skip done valid", valid, 0);
    early = 0;
    for (int i = 1; i <= 8; i++) begin
      send(i);
      if (i < 8 && valid) early++;
    end
    chk("basic early", early, 0);
    chk("basic valid", valid, 1);
    chk("basic busy", busy, 0);
    check_q("basic", seq18);
    rd = 1; step(); rd = 0;
    chk("rd valid", valid, 0);
    chk("rd busy", busy, 0);
    check_q("after rd", seq18);
    // gapped capture
    do_start();
    early = 0;
    for (int i = 0; i < 15; i++) begin
      send(i < 7 ? 8'h55 : i - 6);
      if (i < 14 && valid) early++;
      for (int g = 0; g < 3 && i < 14; g++) begin
        step();
        if (valid) early++;
      end
    end
    chk("gap early", early, 0);
    chk("gap valid", valid, 1);
    check_q("gap", seq18);
    send(9);
    chk("overflow valid", valid, 1);
    check_q("overflow", seq18);
    rd = 1; step(); rd = 0;
    // signed extremes
    do_start();
    for (int i = 0; i < 7; i++) send(0);
    for (int i = 0; i < 8; i++) send(ext[i]);
    chk("ext valid", valid, 1);
    check_q("ext", ext);
    rd = 1; step(); rd = 0;
    // restart mid-fill leaves no residue
    do_start();
    for (int i = 0; i < 7; i++) send(0);
    for (int i = 10; i <= 13; i++) send(i);
    do_start();
    check_q("restart clr", zeros);
    chk("restart busy", busy, 1);
    for (int i = 0; i < 7; i++) send(0);
    for (int i = 21; i <= 28; i++) send(i);
    chk("restart valid", valid, 1);
    check_q("restart", seq21);
    start = 1; rd = 1; step(); start = 0; rd = 0;
    chk("start+rd valid", valid, 0);
    chk("start+rd busy", busy, 1);
    check_q("start+rd", zeros);
    // reset during fill
    for (int i = 0; i < 7; i++) send(0);
    for (int i = 1; i <= 3; i++) send(i);
    rst_n = 0; step(); rst_n = 1;
    chk("midrst valid", valid, 0);
    chk("midrst busy", busy, 0);
    check_q("midrst", zeros);
    for (int i = 0; i < 10; i++) send(40 + i);
    chk("post rst valid", valid, 0);
    chk("post rst busy", busy, 0);
    check_q("post rst", zeros);
    // zero skew, depth 4
    start2 = 1; step(); start2 = 0;
    chk("s0 busy", busy2, 1);
    early = 0;
    for (int i = 5; i <= 8; i++) begin
      en2 = 1; din2 = 8'(i); step(); en2 = 0;
      if (i < 8 && valid2) early++;
    end
    chk("s0 early", early, 0);
    chk("s0 valid", valid2, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("s0 q[%0d]", i), int'(q2[i]), 5 + i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
